// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: shared draw-FSM states, coordinate widths and screen limits.
package vga_draw_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;
endpackage

// File: rtl/box_draw_arbiter_rr.sv
// rr_arbiter2: two-way arbiter; ARB_ROUND_ROBIN_EN selects round robin, else fixed priority to requester 0.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] win_o
);
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // A lone request is already one-hot; on a tie the non-last owner wins.
  assign win_o = (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
  assign last_d = adv_i ? win_o[1] : last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv_i};
  assign win_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
`endif
endmodule

// File: rtl/box_draw_arbiter.sv
// box_draw_arbiter: shares one VGA pixel-write port between two box requesters, plotting one pixel per clock.
// Arbitration policy set by ARB_ROUND_ROBIN_EN (defined: round robin, undefined: fixed priority).
module box_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int BOX_SIZE = 4,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MAX    = Y_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [2*X_W-1:0] x_in,
  input  logic [2*Y_W-1:0] y_in,
  input  logic [2*C_W-1:0] colour_in,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [C_W-1:0]   colour_out,
  output logic             writeEn
);
  localparam int LOG = $clog2(BOX_SIZE);
  localparam int CW = (LOG > 0) ? 2 * LOG : 1;
  localparam logic [CW-1:0] LAST = CW'(BOX_SIZE * BOX_SIZE - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] c_q, c_d;
  logic owner_q, owner_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] win;
  logic adv;
  logic [X_W:0] xs;
  logic [Y_W:0] ys;
  assign adv = (state_q == IDLE) && |req;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .req_i (req),
    .adv_i (adv),
    .win_o (win)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    owner_d = owner_q;
    grant_d = 2'b00;
    case (state_q)
      IDLE: if (adv) begin
        state_d = DRAW;
        cnt_d   = '0;
        owner_d = win[1];
        grant_d = win;
        x_d     = win[1] ? x_in[2*X_W-1:X_W] : x_in[X_W-1:0];
        y_d     = win[1] ? y_in[2*Y_W-1:Y_W] : y_in[Y_W-1:0];
        c_d     = win[1] ? colour_in[2*C_W-1:C_W] : colour_in[C_W-1:0];
      end
      DRAW: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      owner_q <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  // Sums carry one extra bit so off-screen pixels are clipped rather than wrapped.
  assign xs         = {1'b0, x_q} + (X_W+1)'(cnt_q & CW'(BOX_SIZE - 1));
  assign ys         = {1'b0, y_q} + (Y_W+1)'(cnt_q >> LOG);
  assign writeEn    = (state_q == DRAW) && (xs <= (X_W+1)'(X_MAX)) && (ys <= (Y_W+1)'(Y_MAX));
  assign x_out      = xs[X_W-1:0];
  assign y_out      = ys[Y_W-1:0];
  assign colour_out = c_q;
  assign busy       = state_q != IDLE;
  assign grant      = grant_q;
  assign done       = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_box_draw_arbiter.sv
// tb_box_draw_arbiter: directed checks of grant/pixel/done timing, clipping, contention and mid-box reset.
module tb_box_draw_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [15:0] x_in = '0;
  logic [13:0] y_in = '0;
  logic [5:0] colour_in = '0;
  logic [1:0] grant, done;
  logic busy, writeEn;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  int n_chk = 0;
  int n_err = 0;
  int wr;
  box_draw_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .writeEn    (writeEn)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Entered at a negedge with req set up; exits at the negedge of cycle 18 (IDLE).
  task automatic draw_box(input logic [1:0] own, input int xb, input int yb, input int cb,
                          input logic [1:0] req_after, output int writes);
    int xs, ys;
    logic we;
    writes = 0;
    @(posedge clk);
    @(negedge clk);
    chk("grant", 32'(grant), 32'(own));
    req = req_after;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("grant_draw", 32'(grant), 0);
      end
      xs = xb + i % 4;
      ys = yb + i / 4;
      we = (xs <= 159) && (ys <= 119);
      chk("writeEn", 32'(writeEn), 32'(we));
      chk("busy_draw", 32'(busy), 1);
      chk("done_draw", 32'(done), 0);
      chk("x_out", 32'(x_out), xs & 255);
      chk("y_out", 32'(y_out), ys & 127);
      chk("colour", 32'(colour_out), cb);
      if (we) writes++;
    end
    @(negedge clk);
    chk("done", 32'(done), 32'(own));
    chk("we_done", 32'(writeEn), 0);
    chk("busy_done", 32'(busy), 1);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("done_idle", 32'(done), 0);
    chk("grant_idle", 32'(grant), 0);
  endtask
  initial begin
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(writeEn), 0);
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_c", 32'(colour_out), 0);
    @(negedge clk);
    reset = 1'b0;
    // Basic box from requester 0
    x_in = {8'd0, 8'd10};
    y_in = {7'd0, 7'd20};
    colour_in = {3'd0, 3'b100};
    req = 2'b01;
    draw_box(2'b01, 10, 20, 4, 2'b00, wr);
    chk("basic_writes", wr, 16);
    // Clipping at bottom-right corner
    x_in = {8'd0, 8'd158};
    y_in = {7'd0, 7'd118};
    colour_in = {3'd0, 3'b011};
    req = 2'b01;
    draw_box(2'b01, 158, 118, 3, 2'b00, wr);
    chk("clip_writes", wr, 4);
    // Contention from reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    x_in = {8'd50, 8'd30};
    y_in = {7'd60, 7'd40};
    colour_in = {3'd2, 3'd1};
    req = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
    draw_box(2'b01, 30, 40, 1, 2'b10, wr);
    draw_box(2'b10, 50, 60, 2, 2'b00, wr);
`else
    draw_box(2'b01, 30, 40, 1, 2'b11, wr);
    draw_box(2'b01, 30, 40, 1, 2'b00, wr);
`endif
    // Requester 1 arrives while requester 0 is drawing
    x_in = {8'd70, 8'd5};
    y_in = {7'd80, 7'd6};
    colour_in = {3'd6, 3'd7};
    req = 2'b01;
    draw_box(2'b01, 5, 6, 7, 2'b10, wr);
    draw_box(2'b10, 70, 80, 6, 2'b00, wr);
    // Reset in cycle 8 of DRAW
    x_in = {8'd0, 8'd100};
    y_in = {7'd0, 7'd50};
    colour_in = {3'd0, 3'd5};
    req = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'(2'b01));
    req = 2'b00;
    repeat (7) @(negedge clk);
    chk("mid_we_before", 32'(writeEn), 1);
    chk("mid_x_before", 32'(x_out), 103);
    reset = 1'b1;
    #1;
    chk("mid_we_rst", 32'(writeEn), 0);
    chk("mid_busy_rst", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done), 0);
      chk("mid_idle", 32'(busy), 0);
    end
    req = 2'b01;
    draw_box(2'b01, 100, 50, 5, 2'b00, wr);
    chk("after_rst_writes", wr, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
